// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline stage registers and the hazard controller.
// syscall handshake: syscall_go pulses once the pipeline is drained; the host raises
// syscall_ack when done, and all stalls drop in the same cycle the ack is seen.
interface pipeline_hazard_ctrl_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       branch_d;
    logic       jump_reg_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] write_reg_e;
    logic       reg_write_e;
    logic       mem_to_reg_e;
    logic       muldiv_e;
    logic       syscall_e;
    logic [4:0] write_reg_m;
    logic       reg_write_m;
    logic       mem_to_reg_m;
    logic [4:0] write_reg_w;
    logic       reg_write_w;
    logic       syscall_ack;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       flush_e;
    logic       flush_m;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;
    logic       md_busy;
    logic       syscall_go;
    logic [1:0] state_dbg;

    modport master (
        output rs_d, rt_d, branch_d, jump_reg_d, rs_e, rt_e, write_reg_e, reg_write_e,
               mem_to_reg_e, muldiv_e, syscall_e, write_reg_m, reg_write_m, mem_to_reg_m,
               write_reg_w, reg_write_w, syscall_ack,
        input  stall_f, stall_d, stall_e, flush_e, flush_m, fwd_a_e, fwd_b_e, fwd_a_d,
               fwd_b_d, md_busy, syscall_go, state_dbg
    );

    modport slave (
        input  rs_d, rt_d, branch_d, jump_reg_d, rs_e, rt_e, write_reg_e, reg_write_e,
               mem_to_reg_e, muldiv_e, syscall_e, write_reg_m, reg_write_m, mem_to_reg_m,
               write_reg_w, reg_write_w, syscall_ack,
        output stall_f, stall_d, stall_e, flush_e, flush_m, fwd_a_e, fwd_b_e, fwd_a_d,
               fwd_b_d, md_busy, syscall_go, state_dbg
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use and branch
// stalls, multi-cycle mul/div hold in E, and syscall drain/handoff to the host.
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_BUSY   = 2'd1,
        SYS_DRAIN = 2'd2,
        SYS_WAIT  = 2'd3
    } state_t;

    localparam bit               MD_STALL = (MD_CYCLES > 1);
    localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MD_STALL ? MD_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lwstall;
    logic             brstall;
    logic             hazard;
    logic             hold;

    // A producer only counts when it writes a register other than $0.
    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        hz.fwd_a_e = hit(hz.reg_write_m, hz.write_reg_m, hz.rs_e) ? 2'b10 :
                     hit(hz.reg_write_w, hz.write_reg_w, hz.rs_e) ? 2'b01 : 2'b00;
        hz.fwd_b_e = hit(hz.reg_write_m, hz.write_reg_m, hz.rt_e) ? 2'b10 :
                     hit(hz.reg_write_w, hz.write_reg_w, hz.rt_e) ? 2'b01 : 2'b00;
        hz.fwd_a_d = hit(hz.reg_write_m, hz.write_reg_m, hz.rs_d);
        hz.fwd_b_d = hit(hz.reg_write_m, hz.write_reg_m, hz.rt_d);
    end

    always_comb begin
        lwstall = hit(hz.mem_to_reg_e, hz.write_reg_e, hz.rs_d) ||
                  hit(hz.mem_to_reg_e, hz.write_reg_e, hz.rt_d);
        brstall = (hz.branch_d || hz.jump_reg_d) &&
                  (hit(hz.reg_write_e, hz.write_reg_e, hz.rs_d) ||
                   hit(hz.reg_write_e, hz.write_reg_e, hz.rt_d) ||
                   hit(hz.mem_to_reg_m, hz.write_reg_m, hz.rs_d) ||
                   hit(hz.mem_to_reg_m, hz.write_reg_m, hz.rt_d));
        // Outside RUN the E instruction is being held, so it must never be cleared.
        hazard  = (state == RUN) && (lwstall || brstall);

        hold = 1'b0;
        case (state)
            RUN:       hold = (hz.muldiv_e && MD_STALL) || hz.syscall_e;
            MD_BUSY:   hold = (cnt != '0);
            SYS_DRAIN: hold = 1'b1;
            SYS_WAIT:  hold = !hz.syscall_ack;
            default:   hold = 1'b0;
        endcase

        hz.stall_f    = rst_n && (hold || hazard);
        hz.stall_d    = rst_n && (hold || hazard);
        hz.stall_e    = rst_n && hold;
        hz.flush_m    = rst_n && hold;
        hz.flush_e    = hazard;
        hz.md_busy    = (state == MD_BUSY);
        hz.syscall_go = (state == SYS_DRAIN) && (cnt == '0);
        hz.state_dbg  = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.muldiv_e && MD_STALL) begin
                        cnt   <= MD_LOAD;
                        state <= MD_BUSY;
                    end else if (hz.syscall_e) begin
                        cnt   <= CNT_ONE;
                        state <= SYS_DRAIN;
                    end
                end
                MD_BUSY: begin
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                    else           state <= RUN;
                end
                SYS_DRAIN: begin
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                    else           state <= SYS_WAIT;
                end
                SYS_WAIT: begin
                    if (hz.syscall_ack) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: an age-based model of the E instruction
// is checked every cycle, plus hand-computed expectations for each scenario.
module tb_pipeline_hazard_ctrl;
    localparam int MD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz();
    pipeline_hazard_ctrl_if hz1();

    pipeline_hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz.slave)
    );
    pipeline_hazard_ctrl #(.MD_CYCLES(1), .CNT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .hz(hz1.slave)
    );

    int total = 0;
    int bad = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: age = cycles the current E instruction has already spent in E.
    int   age;
    logic last_hold = 1'b0;
    logic m_md, m_sys, m_hold, m_run, m_lw, m_br;
    logic [12:0] exp_v, got_v;

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && dst != 0 && dst == src;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (hit(hz.reg_write_m, hz.write_reg_m, src)) return 2'b10;
        if (hit(hz.reg_write_w, hz.write_reg_w, src)) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) age <= 0;
        else        age <= last_hold ? age + 1 : 0;
    end

    always @(negedge clk) begin : compare
        m_md   = hz.muldiv_e && (MD > 1);
        m_sys  = !m_md && hz.syscall_e;
        m_run  = (age == 0);
        m_hold = m_md ? (age < MD - 1) : (m_sys ? !(age >= 3 && hz.syscall_ack) : 1'b0);
        m_lw   = hz.mem_to_reg_e && hz.write_reg_e != 0 &&
                 (hz.write_reg_e == hz.rs_d || hz.write_reg_e == hz.rt_d);
        m_br   = (hz.branch_d || hz.jump_reg_d) &&
                 ((hz.reg_write_e && hz.write_reg_e != 0 &&
                   (hz.write_reg_e == hz.rs_d || hz.write_reg_e == hz.rt_d)) ||
                  (hz.mem_to_reg_m && hz.write_reg_m != 0 &&
                   (hz.write_reg_m == hz.rs_d || hz.write_reg_m == hz.rt_d)));
        exp_v = {rst_n && (m_hold || (m_run && (m_lw || m_br))),
                 rst_n && (m_hold || (m_run && (m_lw || m_br))),
                 rst_n && m_hold,
                 m_run && (m_lw || m_br),
                 rst_n && m_hold,
                 fwd(hz.rs_e), fwd(hz.rt_e),
                 hit(hz.reg_write_m, hz.write_reg_m, hz.rs_d),
                 hit(hz.reg_write_m, hz.write_reg_m, hz.rt_d),
                 rst_n && m_md && age >= 1,
                 rst_n && m_sys && age == 2};
        got_v = {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_e, hz.flush_m,
                 hz.fwd_a_e, hz.fwd_b_e, hz.fwd_a_d, hz.fwd_b_d, hz.md_busy, hz.syscall_go};
        last_hold = rst_n && m_hold;
        chk("cycle_outputs", {3'b0, got_v}, {3'b0, exp_v});
    end

    task automatic clr_in();
        hz.rs_d = 0; hz.rt_d = 0; hz.branch_d = 0; hz.jump_reg_d = 0;
        hz.rs_e = 0; hz.rt_e = 0; hz.write_reg_e = 0; hz.reg_write_e = 0;
        hz.mem_to_reg_e = 0; hz.muldiv_e = 0; hz.syscall_e = 0;
        hz.write_reg_m = 0; hz.reg_write_m = 0; hz.mem_to_reg_m = 0;
        hz.write_reg_w = 0; hz.reg_write_w = 0; hz.syscall_ack = 0;
    endtask

    task automatic clr_in1();
        hz1.rs_d = 0; hz1.rt_d = 0; hz1.branch_d = 0; hz1.jump_reg_d = 0;
        hz1.rs_e = 0; hz1.rt_e = 0; hz1.write_reg_e = 0; hz1.reg_write_e = 0;
        hz1.mem_to_reg_e = 0; hz1.muldiv_e = 0; hz1.syscall_e = 0;
        hz1.write_reg_m = 0; hz1.reg_write_m = 0; hz1.mem_to_reg_m = 0;
        hz1.write_reg_w = 0; hz1.reg_write_w = 0; hz1.syscall_ack = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    int n_stall;
    int n_busy;
    int n_go;
    int go_idx;

    initial begin
        clr_in();
        clr_in1();
        hz.muldiv_e = 1'b1;
        hz.syscall_e = 1'b1;

        // Reset: requests in E must not produce stalls or state changes.
        @(negedge clk);
        chk("rst_stall", {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_m}, 4'b0000);
        chk("rst_status", {hz.md_busy, hz.syscall_go, hz.state_dbg}, 4'b0000);
        #2 rst_n = 1'b1;
        hz.muldiv_e = 1'b0;
        hz.syscall_e = 1'b0;

        // Forwarding priority and the $0 exclusion.
        next(); hz.reg_write_m = 1; hz.write_reg_m = 3; hz.rs_e = 3;
        @(negedge clk); chk("fwd_a_m", hz.fwd_a_e, 2'b10);
        next(); hz.reg_write_w = 1; hz.write_reg_w = 3;
        @(negedge clk); chk("fwd_a_m_over_w", hz.fwd_a_e, 2'b10);
        next(); hz.write_reg_m = 0; hz.write_reg_w = 0; hz.rs_e = 0;
        @(negedge clk); chk("fwd_a_zero", hz.fwd_a_e, 2'b00);
        next(); hz.write_reg_m = 7; hz.write_reg_w = 3; hz.rs_e = 7; hz.rt_e = 3;
        @(negedge clk); chk("fwd_ab_mixed", {hz.fwd_a_e, hz.fwd_b_e}, 4'b1001);
        next(); hz.reg_write_m = 0;
        @(negedge clk); chk("fwd_m_disabled", {hz.fwd_a_e, hz.fwd_b_e}, 4'b0001);

        // Load-use: one stall cycle, then the consumer forwards from M.
        next(); clr_in(); hz.mem_to_reg_e = 1; hz.reg_write_e = 1; hz.write_reg_e = 5;
        hz.rs_d = 2; hz.rt_d = 5;
        @(negedge clk);
        chk("lw_stall", {hz.stall_f, hz.stall_d, hz.flush_e, hz.stall_e, hz.flush_m}, 5'b11100);
        next(); hz.mem_to_reg_e = 0; hz.reg_write_e = 0; hz.write_reg_e = 0;
        hz.mem_to_reg_m = 1; hz.reg_write_m = 1; hz.write_reg_m = 5;
        @(negedge clk); chk("lw_one_cycle", hz.stall_f, 1'b0);
        next(); hz.mem_to_reg_m = 0; hz.rt_e = 5;
        @(negedge clk); chk("lw_fwd_b_m", hz.fwd_b_e, 2'b10);

        // Branch hazards.
        next(); clr_in(); hz.branch_d = 1; hz.rs_d = 4; hz.rt_d = 9;
        hz.reg_write_e = 1; hz.write_reg_e = 4;
        @(negedge clk); chk("br_stall", {hz.stall_f, hz.flush_e}, 2'b11);
        next(); hz.reg_write_e = 0; hz.write_reg_e = 0; hz.reg_write_m = 1; hz.write_reg_m = 4;
        @(negedge clk); chk("br_fwd_d", {hz.fwd_a_d, hz.fwd_b_d, hz.stall_f}, 3'b100);
        next(); hz.branch_d = 0; hz.jump_reg_d = 1; hz.rs_d = 6;
        hz.mem_to_reg_m = 1; hz.write_reg_m = 6;
        @(negedge clk); chk("jr_load_m_stall", {hz.stall_f, hz.flush_e}, 2'b11);
        next(); clr_in(); hz.branch_d = 1; hz.reg_write_e = 1;
        @(negedge clk); chk("br_zero_reg", hz.stall_f, 1'b0);

        // Mul/div occupies E for 8 cycles, stalling the front 7 of them.
        for (int i = 0; i < 8; i++) exp_q.push_back(i < 7 ? 1'b1 : 1'b0);
        n_stall = 0; n_busy = 0;
        next(); clr_in(); hz.muldiv_e = 1; hz.reg_write_e = 1; hz.write_reg_e = 8;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                next(); hz.branch_d = 1; hz.rs_d = 8;
            end
            @(negedge clk);
            chk("md_stall_f", {15'b0, hz.stall_f}, {15'b0, exp_q.pop_front()});
            n_stall += int'(hz.stall_f);
            n_busy += int'(hz.md_busy);
            if (i == 4) chk("md_flush_e_masked", hz.flush_e, 1'b0);
        end
        chk("md_stall_count", 16'(n_stall), 16'd7);
        chk("md_busy_count", 16'(n_busy), 16'd7);
        next(); clr_in(); hz.reg_write_e = 1; hz.write_reg_e = 9;
        @(negedge clk); chk("md_next_in_e", {hz.stall_e, hz.md_busy, hz.state_dbg}, 4'b0000);

        // MD_CYCLES=1: back-to-back mul ops never stall.
        next(); hz1.muldiv_e = 1;
        @(negedge clk); chk("md1_first", {hz1.stall_f, hz1.stall_e, hz1.md_busy}, 3'b000);
        next();
        @(negedge clk); chk("md1_second", {hz1.stall_f, hz1.stall_e, hz1.md_busy}, 3'b000);
        next(); hz1.muldiv_e = 0;

        // Syscall: spurious ack, drain, pulse on 3rd cycle, ack after 5 wait cycles.
        next(); clr_in(); hz.syscall_ack = 1;
        @(negedge clk); chk("spurious_ack", {hz.stall_f, hz.state_dbg}, 3'b000);
        for (int i = 0; i < 9; i++) exp_q.push_back(i < 8 ? 1'b1 : 1'b0);
        n_go = 0; go_idx = -1;
        next(); hz.syscall_ack = 0; hz.syscall_e = 1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                next(); hz.syscall_ack = (i == 1 || i == 8);
            end
            @(negedge clk);
            chk("sys_stall_f", {15'b0, hz.stall_f}, {15'b0, exp_q.pop_front()});
            if (hz.syscall_go) begin
                n_go++;
                go_idx = i;
            end
        end
        chk("sys_go_count", 16'(n_go), 16'd1);
        chk("sys_go_cycle", 16'(go_idx), 16'd2);
        next(); clr_in();
        @(negedge clk); chk("sys_released", {hz.stall_f, hz.state_dbg}, 3'b000);

        // Async reset in MD_BUSY with cnt=3.
        next(); clr_in(); hz.muldiv_e = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            @(negedge clk);
        end
        chk("mdrst_pre", {hz.state_dbg, hz.stall_e}, 3'b011);
        #2 rst_n = 1'b0;
        #1 chk("mdrst_out", {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_m, hz.md_busy}, 5'b00000);
        chk("mdrst_state", hz.state_dbg, 2'b00);
        hz.muldiv_e = 0;
        @(posedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        next();
        @(negedge clk); chk("mdrst_after", {hz.state_dbg, hz.stall_f, hz.md_busy}, 4'b0000);

        // Async reset in SYS_WAIT.
        next(); hz.syscall_e = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            @(negedge clk);
        end
        chk("sysrst_pre", {hz.state_dbg, hz.stall_f, hz.syscall_go}, 4'b1110);
        #2 rst_n = 1'b0;
        #1 chk("sysrst_out", {hz.stall_f, hz.stall_e, hz.flush_m, hz.syscall_go}, 4'b0000);
        chk("sysrst_state", hz.state_dbg, 2'b00);
        hz.syscall_e = 0;
        @(posedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        next();
        @(negedge clk); chk("sysrst_after", {hz.state_dbg, hz.stall_f, hz.syscall_go}, 4'b0000);

        next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
